// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: register map, field positions and the configuration record
// shared by the performance-counter top level and its channels.
`default_nettype none

package perf_counter_pkg;

  localparam logic [7:0] CTRL_OFS    = 8'h00;
  localparam logic [7:0] STATUS_OFS  = 8'h04;
  localparam logic [7:0] CH_BASE     = 8'h10;
  localparam logic [7:0] SNAP_BASE   = 8'h90;
  localparam logic [7:0] SNAP_SPAN   = 8'h40;

  localparam logic [1:0] SUB_CFG     = 2'd0;
  localparam logic [1:0] SUB_LO      = 2'd1;
  localparam logic [1:0] SUB_HI      = 2'd2;

  localparam int CTRL_GEN            = 0;
  localparam int CTRL_FREEZE         = 1;
  localparam int CTRL_SNAP           = 2;

  localparam int CFG_EVSEL_W         = 4;
  localparam int CFG_EN              = 4;
  localparam int CFG_EDGE            = 5;
  localparam int CFG_OVF_IE          = 6;
  localparam int CFG_W               = 7;

  typedef struct packed {
    logic                   ovf_ie;
    logic                   edge_md;
    logic                   en;
    logic [CFG_EVSEL_W-1:0] evsel;
  } cfg_t;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/perf_counter_ch.sv
// perf_counter_ch: one event counter with its configuration, edge detector,
// overflow flag, tear-free HI shadow and snapshot register.
`default_nettype none

module perf_counter_ch
  import perf_counter_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int N_EV  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_EV-1:0]   events,
  input  logic              count_en,
  input  logic              snap,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              cfg_wr,
  input  logic              lo_wr,
  input  logic              hi_wr,
  input  logic              lo_rd,
  input  logic              ovf_clr,
  output cfg_t              cfg,
  output logic [WIDTH-1:0]  cnt,
  output logic [WIDTH-33:0] shadow,
  output logic [WIDTH-1:0]  snap_val,
  output logic              ovf
);

  localparam int HW = WIDTH - 32;

  logic [N_EV-1:0] prev;
  logic [15:0]     ev_ext;
  logic [15:0]     prev_ext;
  logic            hit;
  logic            inc;
  logic            wrap;

  // Event lines beyond N_EV read as 0, so an out-of-range EVSEL never hits.
  assign ev_ext   = 16'(events);
  assign prev_ext = 16'(prev);
  assign hit      = cfg.edge_md ? (ev_ext[cfg.evsel] & ~prev_ext[cfg.evsel])
                                : ev_ext[cfg.evsel];
  assign inc      = count_en & cfg.en & hit;
  assign wrap     = inc & (&cnt) & ~lo_wr & ~hi_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      cfg      <= '0;
      cnt      <= '0;
      shadow   <= '0;
      snap_val <= '0;
      ovf      <= 1'b0;
    end else begin
      prev <= events;
      if (cfg_wr && be[0]) begin
        cfg <= cfg_t'(wdata[CFG_W-1:0]);
      end
      // A bus write to the counter takes priority and swallows a coincident increment.
      if (lo_wr) begin
        cnt[31:0] <= merge_be(cnt[31:0], wdata, be);
      end else if (hi_wr) begin
        cnt[WIDTH-1:32] <= HW'(merge_be(32'(cnt[WIDTH-1:32]), wdata, be));
      end else if (inc) begin
        cnt <= cnt + WIDTH'(1);
      end
      ovf <= wrap | (ovf & ~ovf_clr);
      if (snap) begin
        snap_val <= cnt;
      end
      if (lo_rd) begin
        shadow <= cnt[WIDTH-1:32];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: memory-mapped bank of N_CH event counters with global
// control, overflow interrupt and all-channel snapshot.
`default_nettype none

module perf_counter_unit
  import perf_counter_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 48,
  parameter int N_EV  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_sel,
  input  logic [7:0]      bus_adr,
  input  logic [3:0]      bus_wren,
  input  logic [31:0]     bus_di,
  output logic [31:0]     bus_do,
  input  logic [N_EV-1:0] events,
  output logic            irq
);

  logic            gen;
  logic            freeze;
  logic            rd;
  logic            wr;
  logic            is_ctrl;
  logic            is_status;
  logic            in_ch;
  logic            in_snap;
  logic [3:0]      ch_idx;
  logic [1:0]      sub;
  logic [7:0]      snap_off;
  logic            ctrl_wr;
  logic            snap_pulse;
  logic            status_wr;
  logic [31:0]     rdata;

  cfg_t             cfg_a  [N_CH];
  logic [WIDTH-1:0] cnt_a  [N_CH];
  logic [WIDTH-1:0] snap_a [N_CH];
  logic [WIDTH-33:0] shd_a [N_CH];
  logic [N_CH-1:0]  ovf;
  logic [N_CH-1:0]  ovf_ie;

  assign rd         = bus_sel & (bus_wren == 4'b0000);
  assign wr         = bus_sel & (|bus_wren);
  assign is_ctrl    = (bus_adr[7:2] == CTRL_OFS[7:2]);
  assign is_status  = (bus_adr[7:2] == STATUS_OFS[7:2]);
  assign in_ch      = (bus_adr >= CH_BASE) && (bus_adr < SNAP_BASE);
  assign ch_idx     = bus_adr[7:4] - 4'd1;
  assign sub        = bus_adr[3:2];
  assign snap_off   = bus_adr - SNAP_BASE;
  assign in_snap    = (bus_adr >= SNAP_BASE) && (snap_off < SNAP_SPAN);
  assign ctrl_wr    = wr & is_ctrl & bus_wren[0];
  assign snap_pulse = ctrl_wr & bus_di[CTRL_SNAP];
  assign status_wr  = wr & is_status & bus_wren[0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel_ch;
    assign sel_ch    = in_ch & (ch_idx == 4'(i));
    assign ovf_ie[i] = cfg_a[i].ovf_ie;

    perf_counter_ch #(
      .WIDTH (WIDTH),
      .N_EV  (N_EV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .events   (events),
      .count_en (gen & ~freeze),
      .snap     (snap_pulse),
      .be       (bus_wren),
      .wdata    (bus_di),
      .cfg_wr   (wr & sel_ch & (sub == SUB_CFG)),
      .lo_wr    (wr & sel_ch & (sub == SUB_LO)),
      .hi_wr    (wr & sel_ch & (sub == SUB_HI)),
      .lo_rd    (rd & sel_ch & (sub == SUB_LO)),
      .ovf_clr  (status_wr & bus_di[i]),
      .cfg      (cfg_a[i]),
      .cnt      (cnt_a[i]),
      .shadow   (shd_a[i]),
      .snap_val (snap_a[i]),
      .ovf      (ovf[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (is_ctrl) begin
      rdata = 32'({freeze, gen});
    end else if (is_status) begin
      rdata = 32'(ovf);
    end else if (in_ch) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_idx == 4'(i)) begin
          case (sub)
            SUB_CFG: rdata = 32'(cfg_a[i]);
            SUB_LO:  rdata = cnt_a[i][31:0];
            SUB_HI:  rdata = 32'(shd_a[i]);
            default: rdata = '0;
          endcase
        end
      end
    end else if (in_snap) begin
      for (int i = 0; i < N_CH; i++) begin
        if (snap_off[5:3] == 3'(i)) begin
          rdata = snap_off[2] ? 32'(snap_a[i][WIDTH-1:32]) : snap_a[i][31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen    <= 1'b0;
      freeze <= 1'b0;
      bus_do <= '0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        gen    <= bus_di[CTRL_GEN];
        freeze <= bus_di[CTRL_FREEZE];
      end
      if (rd) begin
        bus_do <= rdata;
      end
      irq <= |(ovf & ovf_ie);
    end
  end

endmodule

`default_nettype wire
